// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: bundle of the sequencer's control, fetch and decode signals.
//
// Signals:
//   Start    - one-cycle pulse that (re)starts the program at PC 0
//   Instr    - 9-bit instruction read combinationally from memory at PC
//   Zero     - ALU zero flag for the instruction currently issued
//   LutWe    - jump-table write enable (honoured only while idle)
//   LutAddr  - jump-table write index
//   LutData  - jump-table write data (a PC value)
//   PC       - instruction-memory address
//   Opcode   - Instr[8:6]
//   RegSel   - Instr[5:4]
//   Imm      - Instr[3:0]
//   Valid    - issued instruction is live this cycle
//   Done     - program finished, held until the next Start
//   CycleCnt - count of RUN cycles (zero unless the counter is built in)
//
// Modports: slave is the pc_ctrl side, master is the environment side.

interface pc_ctrl_if #(
    parameter int unsigned PC_W = 10
);
    logic            Start;
    logic [8:0]      Instr;
    logic            Zero;
    logic            LutWe;
    logic [3:0]      LutAddr;
    logic [PC_W-1:0] LutData;
    logic [PC_W-1:0] PC;
    logic [2:0]      Opcode;
    logic [1:0]      RegSel;
    logic [3:0]      Imm;
    logic            Valid;
    logic            Done;
    logic [15:0]     CycleCnt;

    modport slave (
        input  Start, Instr, Zero, LutWe, LutAddr, LutData,
        output PC, Opcode, RegSel, Imm, Valid, Done, CycleCnt
    );

    modport master (
        output Start, Instr, Zero, LutWe, LutAddr, LutData,
        input  PC, Opcode, RegSel, Imm, Valid, Done, CycleCnt
    );
endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter and instruction sequencer feeding the ALU.
//
// Holds the PC, drives the instruction-memory address, slices each fetched
// instruction into Opcode/RegSel/Imm, latches the ALU zero flag for
// conditional jumps and runs the Start/Done program handshake. Jump targets
// come from a small table that can only be written while idle.
//
// Ports:
//   Clk   - system clock, all state updates on the rising edge
//   Reset - synchronous, active-high reset (clears the jump table too)
//   bus   - pc_ctrl_if.slave, see the interface file for the signal list
//
// Optional feature: define CYCLE_COUNT_EN to build the saturating 16-bit
// RUN-cycle counter; otherwise CycleCnt is tied to zero.

module pc_ctrl #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned LUT_DEPTH = 16
) (
    input logic      Clk,
    input logic      Reset,
    pc_ctrl_if.slave bus
);

    localparam logic [2:0] OpJmp = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            z_q, z_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];
    logic [PC_W-1:0] lut_d [LUT_DEPTH];

    logic [PC_W-1:0] pc_inc;
    logic            pc_at_end;
    logic            is_jmp;
    logic            taken;
    logic            halt;
    logic [PC_W-1:0] target;
    logic            imm_in_range;
    logic            waddr_in_range;

    // Decode fields are pure slices of the fetched word in every state.
    assign bus.Opcode = bus.Instr[8:6];
    assign bus.RegSel = bus.Instr[5:4];
    assign bus.Imm    = bus.Instr[3:0];

    assign bus.PC    = pc_q;
    assign bus.Valid = valid_q;
    assign bus.Done  = done_q;

    assign pc_inc    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign pc_at_end = (pc_q == {PC_W{1'b1}});
    assign is_jmp    = (bus.Instr[8:6] == OpJmp);

    // Entries beyond the table depth read as target 0 / are not writable.
    assign imm_in_range   = ({28'd0, bus.Instr[3:0]} < LUT_DEPTH);
    assign waddr_in_range = ({28'd0, bus.LutAddr} < LUT_DEPTH);
    assign target         = imm_in_range ? lut_q[bus.Instr[3:0]] : '0;

    // Jump condition lives in RegSel: 00 always, 01 on Z, 10 on !Z, 11 halt.
    always_comb begin
        taken = 1'b0;
        halt  = 1'b0;
        if (is_jmp) begin
            unique case (bus.Instr[5:4])
                2'b00: taken = 1'b1;
                2'b01: taken = z_q;
                2'b10: taken = ~z_q;
                2'b11: halt  = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        z_d     = z_q;
        valid_d = valid_q;
        done_d  = done_q;
        lut_d   = lut_q;

        case (state_q)
            StIdle: begin
                // A write in the Start cycle still lands before the first jump.
                if (bus.LutWe && waddr_in_range) begin
                    lut_d[bus.LutAddr] = bus.LutData;
                end
                if (bus.Start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    z_d     = 1'b0;
                    valid_d = 1'b1;
                    done_d  = 1'b0;
                end
            end

            StRun: begin
                // JMP leaves the latched flag alone so a chain of jumps can
                // all test the last ALU result.
                if (!is_jmp) begin
                    z_d = bus.Zero;
                end
                if (halt) begin
                    state_d = StDone;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (taken) begin
                    pc_d = target;
                end else if (pc_at_end) begin
                    // No wrap: running off the end of memory finishes the program.
                    state_d = StDone;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end
            end

            StDone: begin
                if (bus.Start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    z_d     = 1'b0;
                    valid_d = 1'b1;
                    done_d  = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            z_q     <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            lut_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            lut_q   <= lut_d;
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts every RUN cycle including the halting one; cleared by any
    // accepted Start, frozen outside RUN.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.Start && (state_q != StRun)) begin
            cnt_d = '0;
        end else if ((state_q == StRun) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.CycleCnt = cnt_q;
`else
    assign bus.CycleCnt = '0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: self-checking bench for pc_ctrl. Instruction memory and the
// per-address Zero flag live in bench arrays addressed by the DUT's PC.

module tb_pc_ctrl;

    localparam int PcMax = 1023;
`ifdef CYCLE_COUNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;

    pc_ctrl_if #(.PC_W(10)) ifc ();

    pc_ctrl #(
        .PC_W     (10),
        .LUT_DEPTH(16)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (ifc)
    );

    always #5 Clk = ~Clk;

    logic [8:0] mem  [1024];
    logic       zmem [1024];

    assign ifc.Instr = mem[ifc.PC];
    assign ifc.Zero  = zmem[ifc.PC];

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic start_pulse();
        ifc.Start = 1'b1;
        tick();
        ifc.Start = 1'b0;
    endtask

    function automatic logic [8:0] rand_alu();
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
        if (op == 3'b101) op = 3'b000;
        return {op, 6'($urandom)};
    endfunction

    function automatic logic [8:0] jmp(input logic [1:0] cond, input logic [3:0] imm);
        return {3'b101, cond, imm};
    endfunction

    task automatic fill_alu();
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = rand_alu();
            zmem[i] = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0] cond;
        logic [3:0] imm;
        logic [3:0] waddr;
        logic [9:0] wdata;
        bit         zero;
        bit         same;
        logic [9:0] exp_pc;
        bit         exp_done;
    } jrec_t;

    jrec_t tbl [9];

    // Reference model state for the random programs.
    int m_pc;
    bit m_z;
    bit m_done;
    int m_lut [16];
    int m_cyc;

    initial begin
        Reset       = 1'b0;
        ifc.Start   = 1'b0;
        ifc.LutWe   = 1'b0;
        ifc.LutAddr = '0;
        ifc.LutData = '0;
        fill_alu();

        // Reset state.
        do_reset();
        tick();
        chk("reset_pc", 32'(ifc.PC), 0);
        chk("reset_valid", 32'(ifc.Valid), 0);
        chk("reset_done", 32'(ifc.Done), 0);
        chk("reset_cnt", 32'(ifc.CycleCnt), 0);

        // Five ALU ops then halt.
        fill_alu();
        mem[5] = jmp(2'b11, 4'd0);
        start_pulse();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("seq_pc%0d", i), 32'(ifc.PC), 32'(i));
            chk($sformatf("seq_valid%0d", i), 32'(ifc.Valid), 1);
            chk($sformatf("seq_opcode%0d", i), 32'(ifc.Opcode), 32'(mem[i] >> 6));
            chk($sformatf("seq_imm%0d", i), 32'(ifc.Imm), 32'(mem[i] & 9'h00F));
            tick();
        end
        chk("halt_done", 32'(ifc.Done), 1);
        chk("halt_valid", 32'(ifc.Valid), 0);
        chk("halt_pc", 32'(ifc.PC), 5);
        chk("halt_cnt", 32'(ifc.CycleCnt), CntEn ? 6 : 0);
        tick();
        chk("halt_pc_hold", 32'(ifc.PC), 5);
        chk("halt_done_hold", 32'(ifc.Done), 1);

        // Jump decode table: ALU ops at 0..2 (Zero only at 2), JMP at 3.
        tbl[0] = '{2'b00, 4'd2,  4'd2,  10'd40,   1'b0, 1'b0, 10'd40,   1'b0};
        tbl[1] = '{2'b01, 4'd1,  4'd1,  10'd20,   1'b1, 1'b0, 10'd20,   1'b0};
        tbl[2] = '{2'b01, 4'd1,  4'd1,  10'd20,   1'b0, 1'b0, 10'd4,    1'b0};
        tbl[3] = '{2'b10, 4'd1,  4'd1,  10'd20,   1'b1, 1'b0, 10'd4,    1'b0};
        tbl[4] = '{2'b10, 4'd1,  4'd1,  10'd20,   1'b0, 1'b0, 10'd20,   1'b0};
        tbl[5] = '{2'b00, 4'd4,  4'd4,  10'd99,   1'b0, 1'b1, 10'd99,   1'b0};
        tbl[6] = '{2'b00, 4'd4,  4'd3,  10'd77,   1'b0, 1'b0, 10'd0,    1'b0};
        tbl[7] = '{2'b11, 4'd0,  4'd0,  10'd5,    1'b1, 1'b0, 10'd3,    1'b1};
        tbl[8] = '{2'b00, 4'd15, 4'd15, 10'd1023, 1'b0, 1'b1, 10'd1023, 1'b0};
        for (int r = 0; r < 9; r++) begin
            fill_alu();
            mem[3]  = jmp(tbl[r].cond, tbl[r].imm);
            zmem[2] = tbl[r].zero;
            do_reset();
            ifc.LutWe   = 1'b1;
            ifc.LutAddr = tbl[r].waddr;
            ifc.LutData = tbl[r].wdata;
            if (tbl[r].same) ifc.Start = 1'b1;
            tick();
            ifc.LutWe = 1'b0;
            ifc.Start = 1'b0;
            if (!tbl[r].same) start_pulse();
            tick();
            tick();
            tick();
            chk($sformatf("tbl%0d_pc3", r), 32'(ifc.PC), 3);
            tick();
            chk($sformatf("tbl%0d_pc", r), 32'(ifc.PC), 32'(tbl[r].exp_pc));
            chk($sformatf("tbl%0d_done", r), 32'(ifc.Done), 32'(tbl[r].exp_done));
            chk($sformatf("tbl%0d_valid", r), 32'(ifc.Valid), 32'(!tbl[r].exp_done));
        end

        // Straight-line code runs off the end of memory without wrapping.
        fill_alu();
        do_reset();
        start_pulse();
        for (int i = 0; i < PcMax; i++) tick();
        chk("end_pc_last", 32'(ifc.PC), PcMax);
        chk("end_valid_last", 32'(ifc.Valid), 1);
        tick();
        chk("end_done", 32'(ifc.Done), 1);
        chk("end_pc_hold", 32'(ifc.PC), PcMax);
        chk("end_cnt", 32'(ifc.CycleCnt), CntEn ? 1024 : 0);
        tick();
        chk("end_pc_hold2", 32'(ifc.PC), PcMax);
        chk("end_cnt_hold", 32'(ifc.CycleCnt), CntEn ? 1024 : 0);
        // Restart from DONE.
        start_pulse();
        chk("restart_pc", 32'(ifc.PC), 0);
        chk("restart_done", 32'(ifc.Done), 0);
        chk("restart_valid", 32'(ifc.Valid), 1);
        chk("restart_cnt", 32'(ifc.CycleCnt), 0);

        // Reset mid-RUN clears everything, including the jump table.
        fill_alu();
        do_reset();
        ifc.LutWe   = 1'b1;
        ifc.LutAddr = 4'd5;
        ifc.LutData = 10'd33;
        tick();
        ifc.LutWe = 1'b0;
        start_pulse();
        for (int i = 0; i < 7; i++) tick();
        chk("mid_pc7", 32'(ifc.PC), 7);
        do_reset();
        chk("mid_rst_pc", 32'(ifc.PC), 0);
        chk("mid_rst_valid", 32'(ifc.Valid), 0);
        chk("mid_rst_done", 32'(ifc.Done), 0);
        tick();
        chk("mid_idle_pc", 32'(ifc.PC), 0);
        chk("mid_idle_valid", 32'(ifc.Valid), 0);
        mem[0] = jmp(2'b00, 4'd5);
        start_pulse();
        tick();
        chk("mid_lut_cleared", 32'(ifc.PC), 0);

        // LutWe and Start during RUN are ignored.
        fill_alu();
        mem[4] = jmp(2'b00, 4'd6);
        do_reset();
        ifc.LutWe   = 1'b1;
        ifc.LutAddr = 4'd6;
        ifc.LutData = 10'd50;
        tick();
        ifc.LutWe = 1'b0;
        start_pulse();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ign_pc%0d", i), 32'(ifc.PC), 32'(i));
            ifc.LutWe   = (i == 1);
            ifc.LutData = 10'd99;
            ifc.Start   = (i == 2);
            tick();
            ifc.LutWe = 1'b0;
            ifc.Start = 1'b0;
        end
        chk("ign_target", 32'(ifc.PC), 50);

        // Random programs against a program-level interpreter.
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i]  = 9'($urandom);
                zmem[i] = 1'($urandom);
            end
            do_reset();
            for (int i = 0; i < 16; i++) m_lut[i] = 0;
            for (int w = 0; w < 4; w++) begin
                ifc.LutWe   = 1'b1;
                ifc.LutAddr = 4'($urandom);
                ifc.LutData = 10'($urandom);
                m_lut[ifc.LutAddr] = int'(ifc.LutData);
                tick();
            end
            ifc.LutWe = 1'b0;
            start_pulse();
            m_pc   = 0;
            m_z    = 1'b0;
            m_done = 1'b0;
            m_cyc  = 0;
            for (int s = 0; s < 200 && !m_done; s++) begin
                logic [8:0] ins;
                bit         take;
                chk($sformatf("rnd%0d_pc", it), 32'(ifc.PC), 32'(m_pc));
                chk($sformatf("rnd%0d_valid", it), 32'(ifc.Valid), 1);
                ins  = mem[m_pc];
                take = 1'b0;
                m_cyc++;
                if (ins[8:6] != 3'b101) begin
                    m_z = zmem[m_pc];
                end else if (ins[5:4] == 2'b11) begin
                    m_done = 1'b1;
                end else begin
                    take = (ins[5:4] == 2'b00) || (ins[5:4] == 2'b01 && m_z) ||
                           (ins[5:4] == 2'b10 && !m_z);
                end
                if (!m_done) begin
                    if (take) m_pc = m_lut[ins[3:0]];
                    else if (m_pc == PcMax) m_done = 1'b1;
                    else m_pc = m_pc + 1;
                end
                tick();
            end
            if (m_done) begin
                chk($sformatf("rnd%0d_done", it), 32'(ifc.Done), 1);
                chk($sformatf("rnd%0d_endpc", it), 32'(ifc.PC), 32'(m_pc));
                chk($sformatf("rnd%0d_cnt", it), 32'(ifc.CycleCnt), CntEn ? 32'(m_cyc) : 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
